// File: rtl/sdio_slotmux.sv
// sdio_slotmux: shares one SDIO controller between NSLOT card slots with drained, gapped switching and debounced card detect
module sdio_slotmux #(
    parameter int NSLOT      = 2,
    parameter int NUMIO      = 4,
    parameter int LGDEBOUNCE = 16,
    parameter int GAPCYC     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_sel_valid,
    input  logic [$clog2(NSLOT)-1:0]   i_sel_slot,
    output logic                       o_sel_ready,
    input  logic [7:0]                 i_sdclk,
    input  logic                       i_cmd_en,
    input  logic                       i_pp_cmd,
    input  logic [1:0]                 i_cmd_data,
    input  logic                       i_data_en,
    input  logic                       i_pp_data,
    input  logic [31:0]                i_tx_data,
    input  logic                       i_rx_en,
    output logic [1:0]                 o_cmd_strb,
    output logic [1:0]                 o_cmd_data,
    output logic                       o_card_busy,
    output logic [1:0]                 o_rx_strb,
    output logic [15:0]                o_rx_data,
    output logic [8*NSLOT-1:0]         o_s_sdclk,
    output logic [NSLOT-1:0]           o_s_cmd_en,
    output logic [NSLOT-1:0]           o_s_pp_cmd,
    output logic [2*NSLOT-1:0]         o_s_cmd_data,
    output logic [NSLOT-1:0]           o_s_data_en,
    output logic [NSLOT-1:0]           o_s_pp_data,
    output logic [32*NSLOT-1:0]        o_s_tx_data,
    output logic [NSLOT-1:0]           o_s_rx_en,
    input  logic [2*NSLOT-1:0]         i_s_cmd_strb,
    input  logic [2*NSLOT-1:0]         i_s_cmd_data,
    input  logic [NSLOT-1:0]           i_s_card_busy,
    input  logic [2*NSLOT-1:0]         i_s_rx_strb,
    input  logic [16*NSLOT-1:0]        i_s_rx_data,
    input  logic [NSLOT-1:0]           i_card_detect,
    output logic [NSLOT-1:0]           o_card_present,
    output logic [$clog2(NSLOT)-1:0]   o_active_slot,
    output logic                       o_cd_int,
    input  logic [NSLOT-1:0]           i_cd_clear
);
    localparam int AW = $clog2(NSLOT);
    localparam logic [AW:0] NS = NSLOT[AW:0];

    if (NSLOT < 2 || NSLOT > 8 || !(NUMIO == 1 || NUMIO == 4 || NUMIO == 8) || GAPCYC < 1 || GAPCYC > 255) begin : g_bad_param
        $error("sdio_slotmux: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DRAIN, GAP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           act_q, act_d, nxt_q, nxt_d, rx_sel;
    logic [7:0]              gap_q, gap_d;
    logic                    busy, in_range;
    logic [NSLOT-1:0]        tx_on;
    logic [8*NSLOT-1:0]      s_sdclk_d;
    logic [2*NSLOT-1:0]      s_cmd_data_d;
    logic [32*NSLOT-1:0]     s_tx_data_d;
    logic [NSLOT-1:0]        cd_s1_q, cd_s2_q, pres_d, cd_pend_q;
    logic [LGDEBOUNCE-1:0]   cnt_q [NSLOT];

    assign o_active_slot = act_q;
    assign o_sel_ready   = i_reset_n & ((state_q == IDLE & i_sel_valid & (i_sel_slot == act_q | ~in_range)) | state_q == DONE);

    // Switch FSM next state; RX source flips to the new slot for the last gap cycle
    always_comb begin
        busy     = i_cmd_en | i_data_en | i_rx_en | o_card_busy;
        in_range = {1'b0, i_sel_slot} < NS;
        state_d  = state_q;
        act_d    = act_q;
        nxt_d    = nxt_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: if (i_sel_valid && in_range && i_sel_slot != act_q) begin
                state_d = DRAIN;
                nxt_d   = i_sel_slot;
            end
            DRAIN: if (!busy) begin
                state_d = GAP;
                gap_d   = 8'(GAPCYC - 1);
            end
            GAP: if (gap_q == 8'd0) begin
                state_d = DONE;
                act_d   = nxt_q;
            end else gap_d = gap_q - 8'd1;
            default: state_d = IDLE;
        endcase
        rx_sel = (state_d == GAP && gap_d == 8'd0) ? nxt_d : act_d;
    end

    // Only the slot active next cycle gets controller traffic; everything else sees the idle pattern
    always_comb begin
        tx_on        = (state_d == GAP) ? '0 : NSLOT'(1) << act_d;
        s_sdclk_d    = '0;
        s_cmd_data_d = '1;
        s_tx_data_d  = '1;
        for (int k = 0; k < NSLOT; k++) begin
            s_sdclk_d[8*k +: 8]     = tx_on[k] ? i_sdclk : 8'h00;
            s_cmd_data_d[2*k +: 2]  = tx_on[k] ? i_cmd_data : 2'b11;
            s_tx_data_d[32*k +: 32] = tx_on[k] ? i_tx_data : 32'hFFFF_FFFF;
        end
    end

    // Switch FSM registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            act_q   <= '0;
            nxt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            nxt_q   <= nxt_d;
            gap_q   <= gap_d;
        end
    end

    // Registered per-slot TX drive
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_s_sdclk    <= '0;
            o_s_cmd_en   <= '0;
            o_s_pp_cmd   <= '0;
            o_s_cmd_data <= '1;
            o_s_data_en  <= '0;
            o_s_pp_data  <= '0;
            o_s_tx_data  <= '1;
            o_s_rx_en    <= '0;
        end else begin
            o_s_sdclk    <= s_sdclk_d;
            o_s_cmd_en   <= tx_on & {NSLOT{i_cmd_en}};
            o_s_pp_cmd   <= tx_on & {NSLOT{i_pp_cmd}};
            o_s_cmd_data <= s_cmd_data_d;
            o_s_data_en  <= tx_on & {NSLOT{i_data_en}};
            o_s_pp_data  <= tx_on & {NSLOT{i_pp_data}};
            o_s_tx_data  <= s_tx_data_d;
            o_s_rx_en    <= tx_on & {NSLOT{i_rx_en}};
        end
    end

    // Registered RX return from the selected slot; strobes are suppressed during the gap
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cmd_strb  <= '0;
            o_cmd_data  <= '0;
            o_card_busy <= 1'b0;
            o_rx_strb   <= '0;
            o_rx_data   <= '0;
        end else begin
            o_cmd_strb  <= (state_d == GAP) ? 2'b00 : i_s_cmd_strb[2*int'(rx_sel) +: 2];
            o_cmd_data  <= i_s_cmd_data[2*int'(rx_sel) +: 2];
            o_card_busy <= i_s_card_busy[rx_sel];
            o_rx_strb   <= (state_d == GAP) ? 2'b00 : i_s_rx_strb[2*int'(rx_sel) +: 2];
            o_rx_data   <= i_s_rx_data[16*int'(rx_sel) +: 16];
        end
    end

    // Presence follows the synchronised detect once its counter has saturated
    always_comb begin
        for (int k = 0; k < NSLOT; k++) pres_d[k] = (&cnt_q[k]) ? cd_s2_q[k] : o_card_present[k];
    end

    // Card-detect synchroniser, debounce counters, sticky change flags (set beats clear) and interrupt
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cd_s1_q        <= '0;
            cd_s2_q        <= '0;
            for (int k = 0; k < NSLOT; k++) cnt_q[k] <= '0;
            o_card_present <= '0;
            cd_pend_q      <= '0;
            o_cd_int       <= 1'b0;
        end else begin
            cd_s1_q        <= i_card_detect;
            cd_s2_q        <= cd_s1_q;
            for (int k = 0; k < NSLOT; k++)
                cnt_q[k] <= (cd_s1_q[k] != cd_s2_q[k]) ? '0 : (&cnt_q[k]) ? cnt_q[k] : cnt_q[k] + 1'b1;
            o_card_present <= pres_d;
            cd_pend_q      <= (cd_pend_q & ~i_cd_clear) | (pres_d ^ o_card_present);
            o_cd_int       <= |cd_pend_q;
        end
    end
endmodule

// File: tb/tb_sdio_slotmux.sv
// tb_sdio_slotmux: scoreboard bench for slot switching, pass-through, card detect and reset
module tb_sdio_slotmux;
    localparam int NS = 3;
    localparam int AW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_sel_valid;
    logic [AW-1:0] i_sel_slot;
    logic o_sel_ready;
    logic [7:0] i_sdclk;
    logic i_cmd_en, i_pp_cmd, i_data_en, i_pp_data, i_rx_en;
    logic [1:0] i_cmd_data;
    logic [31:0] i_tx_data;
    logic [1:0] o_cmd_strb, o_cmd_data, o_rx_strb;
    logic o_card_busy;
    logic [15:0] o_rx_data;
    logic [8*NS-1:0] o_s_sdclk;
    logic [NS-1:0] o_s_cmd_en, o_s_pp_cmd, o_s_data_en, o_s_pp_data, o_s_rx_en;
    logic [2*NS-1:0] o_s_cmd_data;
    logic [32*NS-1:0] o_s_tx_data;
    logic [2*NS-1:0] i_s_cmd_strb, i_s_cmd_data, i_s_rx_strb;
    logic [NS-1:0] i_s_card_busy;
    logic [16*NS-1:0] i_s_rx_data;
    logic [NS-1:0] i_card_detect, o_card_present, i_cd_clear;
    logic [AW-1:0] o_active_slot;
    logic o_cd_int;

    int n_run = 0, n_fail = 0;

    typedef struct packed {
        logic [8*NS-1:0]  sdclk;
        logic [NS-1:0]    cmd_en, pp_cmd;
        logic [2*NS-1:0]  cmd_data;
        logic [NS-1:0]    data_en, pp_data;
        logic [32*NS-1:0] tx;
        logic [NS-1:0]    rx_en;
        logic [1:0]       cmd_strb, cmdd;
        logic             busy;
        logic [1:0]       rx_strb;
        logic [15:0]      rx_data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sdio_slotmux #(.NSLOT(NS), .NUMIO(4), .LGDEBOUNCE(4), .GAPCYC(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_sel_valid(i_sel_valid), .i_sel_slot(i_sel_slot), .o_sel_ready(o_sel_ready),
        .i_sdclk(i_sdclk), .i_cmd_en(i_cmd_en), .i_pp_cmd(i_pp_cmd), .i_cmd_data(i_cmd_data),
        .i_data_en(i_data_en), .i_pp_data(i_pp_data), .i_tx_data(i_tx_data), .i_rx_en(i_rx_en),
        .o_cmd_strb(o_cmd_strb), .o_cmd_data(o_cmd_data), .o_card_busy(o_card_busy),
        .o_rx_strb(o_rx_strb), .o_rx_data(o_rx_data),
        .o_s_sdclk(o_s_sdclk), .o_s_cmd_en(o_s_cmd_en), .o_s_pp_cmd(o_s_pp_cmd),
        .o_s_cmd_data(o_s_cmd_data), .o_s_data_en(o_s_data_en), .o_s_pp_data(o_s_pp_data),
        .o_s_tx_data(o_s_tx_data), .o_s_rx_en(o_s_rx_en),
        .i_s_cmd_strb(i_s_cmd_strb), .i_s_cmd_data(i_s_cmd_data), .i_s_card_busy(i_s_card_busy),
        .i_s_rx_strb(i_s_rx_strb), .i_s_rx_data(i_s_rx_data),
        .i_card_detect(i_card_detect), .o_card_present(o_card_present),
        .o_active_slot(o_active_slot), .o_cd_int(o_cd_int), .i_cd_clear(i_cd_clear)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_sdclk = 8'h00; i_cmd_en = 1'b0; i_pp_cmd = 1'b0; i_cmd_data = 2'b11;
        i_data_en = 1'b0; i_pp_data = 1'b0; i_tx_data = '1; i_rx_en = 1'b0;
        i_s_cmd_strb = '0; i_s_cmd_data = '0; i_s_card_busy = '0; i_s_rx_strb = '0; i_s_rx_data = '0;
    endtask

    task automatic rand_in(input bit force_data);
        i_sdclk = 8'($urandom); i_cmd_en = 1'($urandom); i_pp_cmd = 1'($urandom);
        i_cmd_data = 2'($urandom); i_data_en = force_data ? 1'b1 : 1'($urandom);
        i_pp_data = 1'($urandom); i_tx_data = $urandom; i_rx_en = 1'($urandom);
        i_s_cmd_strb = 6'($urandom); i_s_cmd_data = 6'($urandom); i_s_rx_strb = 6'($urandom);
        i_s_card_busy = force_data ? 3'b000 : 3'($urandom);
        i_s_rx_data = 48'({$urandom, $urandom});
    endtask

    function automatic exp_t model(input int s);
        exp_t e;
        bit on;
        e = '0;
        for (int k = 0; k < NS; k++) begin
            on = (k == s);
            e.sdclk[8*k +: 8]     = on ? i_sdclk : 8'h00;
            e.cmd_data[2*k +: 2]  = on ? i_cmd_data : 2'b11;
            e.tx[32*k +: 32]      = on ? i_tx_data : 32'hFFFF_FFFF;
            e.cmd_en[k]  = on & i_cmd_en;
            e.pp_cmd[k]  = on & i_pp_cmd;
            e.data_en[k] = on & i_data_en;
            e.pp_data[k] = on & i_pp_data;
            e.rx_en[k]   = on & i_rx_en;
        end
        e.cmd_strb = i_s_cmd_strb[2*s +: 2];
        e.cmdd     = i_s_cmd_data[2*s +: 2];
        e.busy     = i_s_card_busy[s];
        e.rx_strb  = i_s_rx_strb[2*s +: 2];
        e.rx_data  = i_s_rx_data[16*s +: 16];
        return e;
    endfunction

    task automatic traffic(input int n, input int s, input bit force_data);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rand_in(force_data);
            sb.push_back(model(s));
            tick();
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else begin
                e = sb.pop_front();
                check("sdclk", o_s_sdclk, e.sdclk);
                check("cmd_data", o_s_cmd_data, e.cmd_data);
                check("tx_data", o_s_tx_data, e.tx);
                check("enables", {o_s_cmd_en, o_s_pp_cmd, o_s_data_en, o_s_pp_data, o_s_rx_en},
                      {e.cmd_en, e.pp_cmd, e.data_en, e.pp_data, e.rx_en});
                check("rx_ret", {o_cmd_strb, o_cmd_data, o_card_busy, o_rx_strb, o_rx_data},
                      {e.cmd_strb, e.cmdd, e.busy, e.rx_strb, e.rx_data});
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_sdclk"}, o_s_sdclk, 0);
        check({tag, "_cmdd"}, o_s_cmd_data, 6'h3F);
        check({tag, "_tx"}, o_s_tx_data, {96{1'b1}});
        check({tag, "_en"}, {o_s_cmd_en, o_s_pp_cmd, o_s_data_en, o_s_pp_data, o_s_rx_en}, 0);
        check({tag, "_rx"}, {o_cmd_strb, o_cmd_data, o_card_busy, o_rx_strb, o_rx_data}, 0);
        check({tag, "_rdy"}, o_sel_ready, 0);
        check({tag, "_act"}, o_active_slot, 0);
        check({tag, "_cd"}, {o_cd_int, o_card_present}, 0);
    endtask

    task automatic switch_to(input int s);
        int n = 0;
        i_sel_valid = 1'b1;
        i_sel_slot = AW'(s);
        #1;
        while (!o_sel_ready && n < 40) begin
            tick();
            n++;
        end
        check("switch_ready", o_sel_ready, 1);
        tick();
        i_sel_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_in();
        i_sel_valid = 1'b0; i_sel_slot = '0; i_card_detect = '0; i_cd_clear = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Request the already active slot: immediate ready, traffic keeps flowing
        i_sel_valid = 1'b1; i_sel_slot = 2'd0;
        #1;
        check("same_rdy", o_sel_ready, 1);
        tick();
        i_sel_valid = 1'b0;
        check("same_act", o_active_slot, 0);
        traffic(6, 0, 0);

        // Out-of-range slot is acknowledged without a switch
        idle_in();
        i_sel_valid = 1'b1; i_sel_slot = 2'd3;
        #1;
        check("oor_rdy", o_sel_ready, 1);
        tick();
        i_sel_valid = 1'b0;
        check("oor_act", o_active_slot, 0);
        traffic(3, 0, 0);
        idle_in();
        tick();
        tick();

        // Idle-bus switch 0 -> 1: one drain cycle, eight gap cycles, ready at cycle 10
        i_sdclk = 8'hA5; i_cmd_data = 2'b00;
        i_sel_valid = 1'b1; i_sel_slot = 2'd1;
        #1;
        check("sw1_rdy0", o_sel_ready, 0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 11) i_sel_valid = 1'b0;
            #1;
            check($sformatf("sw1_rdy_c%0d", c), o_sel_ready, c == 10);
            check($sformatf("sw1_sdclk_c%0d", c), o_s_sdclk, c == 1 ? 24'h0000A5 : c <= 9 ? 24'h0 : 24'h00A500);
            check($sformatf("sw1_cmdd_c%0d", c), o_s_cmd_data, c == 1 ? 6'h3C : c <= 9 ? 6'h3F : 6'h33);
        end
        check("sw1_act", o_active_slot, 1);

        // Switch 1 -> 0 while data is busy for 20 clocks: slot 1 traffic is untouched
        i_sel_valid = 1'b1; i_sel_slot = 2'd0;
        traffic(20, 1, 1);
        check("drain_rdy", o_sel_ready, 0);
        check("drain_act", o_active_slot, 1);
        idle_in();
        i_sdclk = 8'h3C;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 10) i_sel_valid = 1'b0;
            #1;
            check($sformatf("sw0_rdy_j%0d", j), o_sel_ready, j == 9);
            check($sformatf("sw0_sdclk_j%0d", j), o_s_sdclk, j <= 8 ? 24'h0 : 24'h00003C);
        end
        check("sw0_act", o_active_slot, 0);
        traffic(8, 0, 0);
        idle_in();

        // Card detect bounce on slot 1, then held high
        for (int i = 0; i < 5; i++) begin
            tick();
            i_card_detect[1] = ~i_card_detect[1];
        end
        for (int j = 1; j <= 19; j++) begin
            tick();
            if (j >= 16) check($sformatf("cd_pres_j%0d", j), o_card_present[1], j >= 18);
        end
        tick();
        check("cd_int_set", o_cd_int, 1);
        i_cd_clear = 3'b010;
        tick();
        i_cd_clear = 3'b000;
        tick();
        check("cd_int_clr", o_cd_int, 0);
        check("cd_pres_keep", o_card_present, 3'b010);

        // Removal on slot 1 with clear landing on the same cycle as the set
        tick();
        i_card_detect[1] = 1'b0;
        for (int j = 1; j <= 17; j++) tick();
        i_cd_clear = 3'b010;
        tick();
        i_cd_clear = 3'b000;
        check("rm_pres", o_card_present[1], 0);
        tick();
        tick();
        check("set_wins_a", o_cd_int, 1);
        tick();
        check("set_wins_b", o_cd_int, 1);
        i_cd_clear = 3'b010;
        tick();
        i_cd_clear = 3'b000;
        tick();
        check("rm_clr", o_cd_int, 0);

        // Reset in the middle of a gap abandons the switch
        i_card_detect[0] = 1'b1;
        switch_to(1);
        repeat (20) tick();
        check("pre_rst_pres", o_card_present[0], 1);
        check("pre_rst_int", o_cd_int, 1);
        check("pre_rst_act", o_active_slot, 1);
        i_s_rx_data = '1;
        i_sel_valid = 1'b1; i_sel_slot = 2'd2;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("gaprst");
        tick();
        i_sel_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_act", o_active_slot, 0);
        i_sel_valid = 1'b1; i_sel_slot = 2'd0;
        #1;
        check("post_rst_rdy", o_sel_ready, 1);
        tick();
        i_sel_valid = 1'b0;
        check("post_rst_sdclk", o_s_sdclk, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/sdio_slotmux.md
SDIO_SLOTMUX -- requirements
Module: sdio_slotmux

Interface
REQ-001 SHALL have parameter NSLOT, default 2, meaning the number of card slots sharing one controller (legal range 2..8).
REQ-002 SHALL have parameter NUMIO, default 4, meaning the data lines per slot (1, 4 or 8).
REQ-003 SHALL have parameter LGDEBOUNCE, default 16, meaning the card-detect stable time of 2^LGDEBOUNCE clocks.
REQ-004 SHALL have parameter GAPCYC, default 8, meaning the idle clocks inserted between slots on a switch (range 1..255).
REQ-005 Port list: clock and reset are single clock i_clk with asynchronous active-low reset i_reset_n; both input, 1 bit.
REQ-006 Slot-select request ports: i_sel_valid in 1; i_sel_slot in $clog2(NSLOT); o_sel_ready out 1.
REQ-007 Controller TX ports, all inputs: i_sdclk 8; i_cmd_en 1; i_pp_cmd 1; i_cmd_data 2; i_data_en 1; i_pp_data 1; i_tx_data 32; i_rx_en 1.
REQ-008 Controller RX ports, all outputs: o_cmd_strb 2; o_cmd_data 2; o_card_busy 1; o_rx_strb 2; o_rx_data 16.
REQ-009 Per-slot TX ports, all outputs, each packed slot-major with slot 0 in the LSBs: o_s_sdclk 8*NSLOT; o_s_cmd_en NSLOT; o_s_pp_cmd NSLOT; o_s_cmd_data 2*NSLOT; o_s_data_en NSLOT; o_s_pp_data NSLOT; o_s_tx_data 32*NSLOT; o_s_rx_en NSLOT.
REQ-010 Per-slot RX ports, all inputs, same packing: i_s_cmd_strb 2*NSLOT; i_s_cmd_data 2*NSLOT; i_s_card_busy NSLOT; i_s_rx_strb 2*NSLOT; i_s_rx_data 16*NSLOT.
REQ-011 Card-detect and status ports:
- i_card_detect in NSLOT, raw and asynchronous.
- o_card_present out NSLOT.
- o_active_slot out $clog2(NSLOT).
- o_cd_int out 1.
- i_cd_clear in NSLOT, write-1-to-clear.

Function
REQ-012 busy SHALL be defined as i_cmd_en | i_data_en | i_rx_en | o_card_busy, where o_card_busy is the active slot's busy.
REQ-013 FSM states SHALL be IDLE, DRAIN, GAP, DONE.
REQ-014 In IDLE with i_sel_valid, i_sel_slot == active, and the slot in range, o_sel_ready SHALL assert the same cycle and the state SHALL stay IDLE.
REQ-015 In IDLE with i_sel_valid and a different in-range slot, the request SHALL be latched and the next state SHALL be DRAIN; o_sel_ready SHALL be 0.
REQ-016 An out-of-range i_sel_slot (>= NSLOT) SHALL be acknowledged immediately with no change of active slot.
REQ-017 DRAIN SHALL pass all traffic to the current slot and move to GAP on the first cycle busy is 0.
REQ-018 GAP SHALL drive every slot idle for exactly GAPCYC clocks, then load the active slot from the latch and enter DONE.
- Idle drive: sdclk 8'h00; cmd_en, data_en, rx_en, pp_cmd, pp_data 0; cmd_data 2'b11; tx_data all ones.
REQ-019 DONE SHALL assert o_sel_ready for one cycle and return to IDLE.
REQ-020 Controller TX inputs SHALL reach the active slot's outputs registered with 1-clock latency, except in GAP.
REQ-021 Non-active slots SHALL always be driven idle.
REQ-022 RX outputs SHALL be the active slot's inputs registered with 1-clock latency.
REQ-023 In GAP, o_cmd_strb and o_rx_strb SHALL be forced to 0, and o_card_busy SHALL reflect the new slot from the last GAP cycle onward.
REQ-024 i_sel_valid SHALL be ignored outside IDLE; the requester SHALL hold its request until o_sel_ready.
REQ-025 Card detect, each slot independently:
- 2-flop synchroniser, then an LGDEBOUNCE-bit counter.
- The counter resets on any change of the synchronised value.
- o_card_present updates when the counter saturates at all-ones.
REQ-026 Each change of o_card_present[k] SHALL set sticky bit cd_pend[k]; i_cd_clear[k] SHALL clear it.
- If set and clear occur in the same cycle, set SHALL win.
REQ-027 o_cd_int SHALL be the registered OR of cd_pend.
REQ-028 o_active_slot SHALL equal the registered active-slot value.

Reset
REQ-029 While i_reset_n is low, all state SHALL clear asynchronously:
- FSM to IDLE; active slot 0.
- All TX outputs idle per REQ-018; all RX outputs 0.
- o_sel_ready 0; cd_pend 0; o_cd_int 0; debounce counters 0; o_card_present 0.
REQ-030 Deassertion of i_reset_n SHALL take effect on the next rising i_clk edge; any switch in progress at reset SHALL be abandoned.

Verification
REQ-031 Reset, then request slot 0 -> o_sel_ready asserts the same cycle, o_active_slot=0, no GAP.
REQ-032 With the bus idle, request slot 1 -> DRAIN 1 clock, all slots idle 8 clocks, o_sel_ready high at cycle 10, o_active_slot=1.
REQ-033 Request slot 1 while i_data_en=1 for 20 clocks -> slot 0 traffic is uninterrupted for those 20 clocks, then 8 idle clocks, then ready.
REQ-034 With LGDEBOUNCE=4, toggle i_card_detect[1] for 5 clocks then hold it high -> o_card_present[1]=1 exactly 2+16 clocks after the last edge, and o_cd_int=1.
REQ-035 Pulse i_cd_clear[1] in the same cycle a new present change on slot 1 sets its pending bit -> cd_pend[1] stays 1 and o_cd_int stays 1.
REQ-036 Drop i_reset_n during GAP -> all outputs immediately reach reset values; after release, o_active_slot=0.
